fma_special_case_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational special-case detector in the FMA front end.
- Classifies A, B and C as sNaN, qNaN, Inf, Zero, Denormal or Normal.
- Resolves the IEEE-754 special-case FMA result (NaN propagation, invalid ops, infinity arithmetic) under a valid/ready handshake.
- Sits between the operand issue stage and the multiplier/aligner; when `special_o` is set, the main datapath result is bypassed.

---
 rtl/fma_pkg.sv | 37 +++
 rtl/fp_operand_classifier.sv | 45 ++++
 rtl/fma_special_case_pipe.sv | 166 ++++++++++++++++
 tb/tb_fma_special_case_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared FMA front-end definitions: operand class bit positions, op encodings, canonical qNaN.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package fma_pkg;

    localparam int CLS_W    = 6;
    localparam int CLS_SNAN = 5;
    localparam int CLS_QNAN = 4;
    localparam int CLS_INF  = 3;
    localparam int CLS_ZERO = 2;
    localparam int CLS_DEN  = 1;
    localparam int CLS_NORM = 0;

    typedef logic [CLS_W-1:0] cls_vec_t;

    localparam logic [1:0] OP_FMADD  = 2'b00;
    localparam logic [1:0] OP_FMSUB  = 2'b10;
    localparam logic [1:0] OP_FNMSUB = 2'b01;
    localparam logic [1:0] OP_FNMADD = 2'b11;
    localparam int         OP_NEG_PROD = 0;
    localparam int         OP_NEG_ADD  = 1;

    localparam int QNAN_MAX_W = 128;

    // Wide result so any format up to 128 bits can slice its own width out.
    function automatic logic [QNAN_MAX_W-1:0] canonical_qnan(input int exp_w, input int mant_w);
        logic [QNAN_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < QNAN_MAX_W; i++) begin
            if (i >= mant_w - 1 && i < mant_w + exp_w) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_operand_classifier.sv
// One-hot IEEE-754 operand classifier {sNaN, qNaN, Inf, Zero, DeN, Norm}; FMA_SPECIAL_DAZ_EN folds DeN into Zero.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module fp_operand_classifier
    import fma_pkg::*;
#(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic [PARM_EXP-1:0]  exp_i,
    input  logic [PARM_MANT-1:0] mant_i,
    output logic [CLS_W-1:0]     class_o
);

    logic exp_ones;
    logic mant_zero;
    logic lead_bit;

    always_comb begin
        exp_ones  = &exp_i;
        mant_zero = ~|mant_i;
        lead_bit  = |exp_i;
        class_o   = '0;
        if (exp_ones) begin
            if (mant_zero) begin
                class_o[CLS_INF] = 1'b1;
            end else if (mant_i[PARM_MANT-1]) begin
                class_o[CLS_QNAN] = 1'b1;
            end else begin
                class_o[CLS_SNAN] = 1'b1;
            end
        end else if (lead_bit) begin
            class_o[CLS_NORM] = 1'b1;
        end else if (mant_zero) begin
            class_o[CLS_ZERO] = 1'b1;
        end else begin
`ifdef FMA_SPECIAL_DAZ_EN
            class_o[CLS_ZERO] = 1'b1;
`else
            class_o[CLS_DEN] = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/fma_special_case_pipe.sv
// FMA special-case resolver: classifies A/B/C and produces NaN/Inf/invalid bypass results (FMA_SPECIAL_DAZ_EN = DAZ).
// Latency: 2 cycles accept-to-out_valid_o, throughput 1 per cycle.
// Backpressure: valid/ready per stage; in_ready_o depends on out_ready_i, never on in_valid_i.
module fma_special_case_pipe
    import fma_pkg::*;
#(
    parameter int PARM_XLEN = 32,
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PARM_XLEN-1:0] A_i,
    input  logic [PARM_XLEN-1:0] B_i,
    input  logic [PARM_XLEN-1:0] C_i,
    input  logic [1:0]           op_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CLS_W-1:0]     A_class_o,
    output logic [CLS_W-1:0]     B_class_o,
    output logic [CLS_W-1:0]     C_class_o,
    output logic                 special_o,
    output logic [PARM_XLEN-1:0] result_o,
    output logic                 invalid_o
);

    localparam logic [QNAN_MAX_W-1:0] QNAN_WIDE = canonical_qnan(PARM_EXP, PARM_MANT);
    localparam logic [PARM_XLEN-1:0]  QNAN      = QNAN_WIDE[PARM_XLEN-1:0];
    localparam logic [PARM_XLEN-2:0]  INF_MAG   = {{PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};

    logic [CLS_W-1:0] a_cls, b_cls, c_cls;

    fp_operand_classifier #(.PARM_EXP(PARM_EXP), .PARM_MANT(PARM_MANT)) u_cls_a (
        .exp_i(A_i[PARM_XLEN-2 -: PARM_EXP]), .mant_i(A_i[PARM_MANT-1:0]), .class_o(a_cls));
    fp_operand_classifier #(.PARM_EXP(PARM_EXP), .PARM_MANT(PARM_MANT)) u_cls_b (
        .exp_i(B_i[PARM_XLEN-2 -: PARM_EXP]), .mant_i(B_i[PARM_MANT-1:0]), .class_o(b_cls));
    fp_operand_classifier #(.PARM_EXP(PARM_EXP), .PARM_MANT(PARM_MANT)) u_cls_c (
        .exp_i(C_i[PARM_XLEN-2 -: PARM_EXP]), .mant_i(C_i[PARM_MANT-1:0]), .class_o(c_cls));

    // Resolution only needs the signs, so S1 keeps the sign bits rather than full operands.
    logic                 s1_vld_q, s1_vld_d;
    logic [2:0]           s1_sgn_q, s1_sgn_d;
    logic [1:0]           s1_op_q, s1_op_d;
    logic [CLS_W-1:0]     s1_a_cls_q, s1_a_cls_d, s1_b_cls_q, s1_b_cls_d, s1_c_cls_q, s1_c_cls_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [CLS_W-1:0]     s2_a_cls_q, s2_a_cls_d, s2_b_cls_q, s2_b_cls_d, s2_c_cls_q, s2_c_cls_d;
    logic                 s2_special_q, s2_special_d;
    logic [PARM_XLEN-1:0] s2_result_q, s2_result_d;
    logic                 s2_invalid_q, s2_invalid_d;

    logic                 s1_adv, s2_adv;
    logic                 prod_sgn, add_sgn, prod_inf, inf_x_zero, any_snan, any_qnan;
    logic                 res_special, res_invalid;
    logic [PARM_XLEN-1:0] res_result;

    always_comb begin
        s2_adv = ~s2_vld_q | out_ready_i;
        s1_adv = ~s1_vld_q | s2_adv;

        prod_sgn   = s1_sgn_q[2] ^ s1_sgn_q[1] ^ s1_op_q[OP_NEG_PROD];
        add_sgn    = s1_sgn_q[0] ^ s1_op_q[OP_NEG_ADD];
        any_snan   = s1_a_cls_q[CLS_SNAN] | s1_b_cls_q[CLS_SNAN] | s1_c_cls_q[CLS_SNAN];
        any_qnan   = s1_a_cls_q[CLS_QNAN] | s1_b_cls_q[CLS_QNAN] | s1_c_cls_q[CLS_QNAN];
        inf_x_zero = (s1_a_cls_q[CLS_INF] & s1_b_cls_q[CLS_ZERO]) |
                     (s1_a_cls_q[CLS_ZERO] & s1_b_cls_q[CLS_INF]);
        prod_inf   = (s1_a_cls_q[CLS_INF] | s1_b_cls_q[CLS_INF]) &
                     ~s1_a_cls_q[CLS_ZERO] & ~s1_b_cls_q[CLS_ZERO];

        res_special = 1'b1;
        res_invalid = 1'b0;
        res_result  = '0;
        if (any_snan | inf_x_zero | (prod_inf & s1_c_cls_q[CLS_INF] & (prod_sgn != add_sgn))) begin
            res_result  = QNAN;
            res_invalid = 1'b1;
        end else if (any_qnan) begin
            res_result = QNAN;
        end else if (prod_inf) begin
            res_result = {prod_sgn, INF_MAG};
        end else if (s1_c_cls_q[CLS_INF]) begin
            res_result = {add_sgn, INF_MAG};
        end else begin
            res_special = 1'b0;
        end

        s1_vld_d   = s1_vld_q;
        s1_sgn_d   = s1_sgn_q;
        s1_op_d    = s1_op_q;
        s1_a_cls_d = s1_a_cls_q;
        s1_b_cls_d = s1_b_cls_q;
        s1_c_cls_d = s1_c_cls_q;
        if (s1_adv) begin
            s1_vld_d = in_valid_i;
        end
        if (s1_adv & in_valid_i) begin
            s1_sgn_d   = {A_i[PARM_XLEN-1], B_i[PARM_XLEN-1], C_i[PARM_XLEN-1]};
            s1_op_d    = op_i;
            s1_a_cls_d = a_cls;
            s1_b_cls_d = b_cls;
            s1_c_cls_d = c_cls;
        end

        // Bubbles leave the S2 payload untouched so outputs hold their last values.
        s2_vld_d     = s2_vld_q;
        s2_a_cls_d   = s2_a_cls_q;
        s2_b_cls_d   = s2_b_cls_q;
        s2_c_cls_d   = s2_c_cls_q;
        s2_special_d = s2_special_q;
        s2_result_d  = s2_result_q;
        s2_invalid_d = s2_invalid_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
        end
        if (s2_adv & s1_vld_q) begin
            s2_a_cls_d   = s1_a_cls_q;
            s2_b_cls_d   = s1_b_cls_q;
            s2_c_cls_d   = s1_c_cls_q;
            s2_special_d = res_special;
            s2_result_d  = res_result;
            s2_invalid_d = res_invalid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q     <= 1'b0;
            s1_sgn_q     <= '0;
            s1_op_q      <= '0;
            s1_a_cls_q   <= '0;
            s1_b_cls_q   <= '0;
            s1_c_cls_q   <= '0;
            s2_vld_q     <= 1'b0;
            s2_a_cls_q   <= '0;
            s2_b_cls_q   <= '0;
            s2_c_cls_q   <= '0;
            s2_special_q <= 1'b0;
            s2_result_q  <= '0;
            s2_invalid_q <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_sgn_q     <= s1_sgn_d;
            s1_op_q      <= s1_op_d;
            s1_a_cls_q   <= s1_a_cls_d;
            s1_b_cls_q   <= s1_b_cls_d;
            s1_c_cls_q   <= s1_c_cls_d;
            s2_vld_q     <= s2_vld_d;
            s2_a_cls_q   <= s2_a_cls_d;
            s2_b_cls_q   <= s2_b_cls_d;
            s2_c_cls_q   <= s2_c_cls_d;
            s2_special_q <= s2_special_d;
            s2_result_q  <= s2_result_d;
            s2_invalid_q <= s2_invalid_d;
        end
    end

    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_vld_q;
    assign A_class_o   = s2_a_cls_q;
    assign B_class_o   = s2_b_cls_q;
    assign C_class_o   = s2_c_cls_q;
    assign special_o   = s2_special_q;
    assign result_o    = s2_result_q;
    assign invalid_o   = s2_invalid_q;

endmodule

// File: tb/tb_fma_special_case_pipe.sv
// Self-checking bench for fma_special_case_pipe: directed vectors with literal expectations plus a
// scoreboard model of the IEEE special-case rules compared on every valid output cycle.
module tb_fma_special_case_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] A_i, B_i, C_i;
    logic [1:0]  op_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  A_class_o, B_class_o, C_class_o;
    logic        special_o;
    logic [31:0] result_o;
    logic        invalid_o;

    fma_special_case_pipe dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .A_i(A_i), .B_i(B_i), .C_i(C_i), .op_i(op_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .A_class_o(A_class_o), .B_class_o(B_class_o), .C_class_o(C_class_o),
        .special_o(special_o), .result_o(result_o), .invalid_o(invalid_o));

    always #5 clk_i = ~clk_i;

    localparam logic [5:0] K_SNAN = 6'b100000;
    localparam logic [5:0] K_QNAN = 6'b010000;
    localparam logic [5:0] K_INF  = 6'b001000;
    localparam logic [5:0] K_ZERO = 6'b000100;
    localparam logic [5:0] K_DEN  = 6'b000010;
    localparam logic [5:0] K_NORM = 6'b000001;
`ifdef FMA_SPECIAL_DAZ_EN
    localparam logic [5:0] K_TINY = K_ZERO;
    localparam bit         DAZ    = 1'b1;
`else
    localparam logic [5:0] K_TINY = K_DEN;
    localparam bit         DAZ    = 1'b0;
`endif

    typedef struct {
        logic [5:0]  ac, bc, cc;
        logic        sp;
        logic [31:0] res;
        logic        inv;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [5:0] m_class(input logic [31:0] x);
        int unsigned e, m;
        e = (x >> 23) & 32'hFF;
        m = x & 32'h7FFFFF;
        if (e == 255) begin
            if (m == 0) return K_INF;
            return (m >= 32'h400000) ? K_QNAN : K_SNAN;
        end
        if (e == 0) return (m == 0) ? K_ZERO : K_TINY;
        return K_NORM;
    endfunction

    function automatic exp_t m_resolve(input logic [31:0] a, b, c, input logic [1:0] op);
        exp_t r;
        bit ps, cs, p_inf, inf_zero, any_s, any_q;
        r.ac = m_class(a);
        r.bc = m_class(b);
        r.cc = m_class(c);
        ps = a[31] ^ b[31] ^ op[0];
        cs = c[31] ^ op[1];
        any_s = (r.ac == K_SNAN) || (r.bc == K_SNAN) || (r.cc == K_SNAN);
        any_q = (r.ac == K_QNAN) || (r.bc == K_QNAN) || (r.cc == K_QNAN);
        inf_zero = (r.ac == K_INF && r.bc == K_ZERO) || (r.ac == K_ZERO && r.bc == K_INF);
        p_inf = (r.ac == K_INF || r.bc == K_INF) && r.ac != K_ZERO && r.bc != K_ZERO;
        r.sp = 1'b1;
        r.inv = 1'b0;
        if (any_s || inf_zero || (p_inf && r.cc == K_INF && ps != cs)) begin
            r.res = 32'h7FC00000;
            r.inv = 1'b1;
        end else if (any_q) r.res = 32'h7FC00000;
        else if (p_inf) r.res = ps ? 32'hFF800000 : 32'h7F800000;
        else if (r.cc == K_INF) r.res = cs ? 32'hFF800000 : 32'h7F800000;
        else begin
            r.sp = 1'b0;
            r.res = 32'h0;
        end
        return r;
    endfunction

    // Scoreboard: every valid output cycle is compared against the oldest outstanding model entry.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
        end else begin
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    chk("mon_unexpected_out_valid", 32'(out_valid_o), 32'd0);
                end else begin
                    chk("mon_a_class", 32'(A_class_o), 32'(q[0].ac));
                    chk("mon_b_class", 32'(B_class_o), 32'(q[0].bc));
                    chk("mon_c_class", 32'(C_class_o), 32'(q[0].cc));
                    chk("mon_special", 32'(special_o), 32'(q[0].sp));
                    chk("mon_result", result_o, q[0].res);
                    chk("mon_invalid", 32'(invalid_o), 32'(q[0].inv));
                    if (out_ready_i) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid_i && in_ready_o) q.push_back(m_resolve(A_i, B_i, C_i, op_i));
        end
    end

    task automatic send(input logic [31:0] a, b, c, input logic [1:0] op);
        bit got;
        got = 1'b0;
        A_i = a; B_i = b; C_i = c; op_i = op;
        in_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send_timeout", 32'(got), 32'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic directed(input string name, input logic [31:0] a, b, c, input logic [1:0] op,
                            input logic [5:0] eac, ebc, ecc, input logic esp,
                            input logic [31:0] eres, input logic einv);
        out_ready_i = 1'b1;
        send(a, b, c, op);
        @(negedge clk_i);
        chk({name, "_lat1_vld"}, 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        chk({name, "_lat2_vld"}, 32'(out_valid_o), 32'd1);
        chk({name, "_a_class"}, 32'(A_class_o), 32'(eac));
        chk({name, "_b_class"}, 32'(B_class_o), 32'(ebc));
        chk({name, "_c_class"}, 32'(C_class_o), 32'(ecc));
        chk({name, "_special"}, 32'(special_o), 32'(esp));
        chk({name, "_result"}, result_o, eres);
        chk({name, "_invalid"}, 32'(invalid_o), 32'(einv));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_base;
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        A_i = '0; B_i = '0; C_i = '0; op_i = '0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_special", 32'(special_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_invalid", 32'(invalid_o), 32'd0);
        chk("rst_a_class", 32'(A_class_o), 32'd0);
        @(posedge clk_i);
        #1;

        directed("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h3F800000, 2'b00,
                 K_INF, K_ZERO, K_NORM, 1'b1, 32'h7FC00000, 1'b1);
        directed("inf_minus_inf", 32'h7F800000, 32'h3F800000, 32'hFF800000, 2'b00,
                 K_INF, K_NORM, K_INF, 1'b1, 32'h7FC00000, 1'b1);
        directed("fmsub_inf", 32'h7F800000, 32'h3F800000, 32'hFF800000, 2'b10,
                 K_INF, K_NORM, K_INF, 1'b1, 32'h7F800000, 1'b0);
        directed("snan_a", 32'h7F800001, 32'h40000000, 32'h40000000, 2'b00,
                 K_SNAN, K_NORM, K_NORM, 1'b1, 32'h7FC00000, 1'b1);
        directed("qnan_a", 32'h7FC00001, 32'h40000000, 32'h40000000, 2'b00,
                 K_QNAN, K_NORM, K_NORM, 1'b1, 32'h7FC00000, 1'b0);
        directed("all_norm", 32'h40000000, 32'hC0000000, 32'h3F800000, 2'b00,
                 K_NORM, K_NORM, K_NORM, 1'b0, 32'h00000000, 1'b0);
        directed("denorm_a", 32'h00000001, 32'h3F800000, 32'h3F800000, 2'b00,
                 DAZ ? K_ZERO : K_DEN, K_NORM, K_NORM, 1'b0, 32'h00000000, 1'b0);
        directed("fnmadd_neg_inf", 32'hFF800000, 32'h3F800000, 32'h3F800000, 2'b11,
                 K_INF, K_NORM, K_NORM, 1'b1, 32'h7F800000, 1'b0);
        directed("fnmsub_c_inf", 32'h3F800000, 32'h3F800000, 32'hFF800000, 2'b01,
                 K_NORM, K_NORM, K_INF, 1'b1, 32'hFF800000, 1'b0);
        directed("inf_x_denorm", 32'h7F800000, 32'h00000001, 32'h00000000, 2'b00,
                 K_INF, DAZ ? K_ZERO : K_DEN, K_ZERO, 1'b1,
                 DAZ ? 32'h7FC00000 : 32'h7F800000, DAZ ? 1'b1 : 1'b0);

        // Backpressure: out_ready_i low for 5 cycles while four operands are offered back to back.
        out_base = n_out;
        out_ready_i = 1'b0;
        send(32'h7F800000, 32'h00000000, 32'h3F800000, 2'b00);
        send(32'h40000000, 32'hC0000000, 32'h3F800000, 2'b00);
        A_i = 32'h7FC00001; B_i = 32'h40000000; C_i = 32'h40000000; op_i = 2'b00;
        in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("bp_in_ready_low", 32'(in_ready_o), 32'd0);
            chk("bp_out_valid_held", 32'(out_valid_o), 32'd1);
            @(posedge clk_i);
            #1;
        end
        out_ready_i = 1'b1;
        send(32'h7FC00001, 32'h40000000, 32'h40000000, 2'b00);
        send(32'h3F800000, 32'h3F800000, 32'hFF800000, 2'b01);
        repeat (4) @(posedge clk_i);
        #1;
        chk("bp_outputs_delivered", 32'(n_out - out_base), 32'd4);
        chk("bp_queue_drained", 32'(q.size()), 32'd0);

        // Reset with both stages full must discard everything in flight.
        out_ready_i = 1'b0;
        send(32'h7F800001, 32'h40000000, 32'h40000000, 2'b00);
        send(32'hFF800000, 32'h3F800000, 32'h3F800000, 2'b11);
        @(negedge clk_i);
        chk("pre_rst_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_special", 32'(special_o), 32'd0);
        chk("mid_rst_invalid", 32'(invalid_o), 32'd0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("rst_no_stale", 32'(out_valid_o), 32'd0);
        end

        @(posedge clk_i);
        #1;
        directed("post_rst", 32'h7F800000, 32'h3F800000, 32'h40000000, 2'b01,
                 K_INF, K_NORM, K_NORM, 1'b1, 32'hFF800000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
